// File: rtl/st_reg_ram_bypass_pkg.sv
// Shared types and entry-layout constants for the envelope state store.
package st_reg_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } st_state_e;

    localparam int ST_LEVEL_LSB    = 0;
    localparam int ST_LEVEL_W      = 16;
    localparam int ST_OLDLEVEL_LSB = 16;
    localparam int ST_OLDLEVEL_W   = 16;
    localparam int ST_DISTANCE_LSB = 32;
    localparam int ST_DISTANCE_W   = 18;
    localparam int ST_ST_LSB       = 50;
    localparam int ST_ST_W         = 3;
    localparam int ST_ENTRY_W      = ST_ST_LSB + ST_ST_W;

    function automatic int st_addr_w(input int v_width, input int e_width);
        return v_width + e_width;
    endfunction

endpackage

// File: rtl/st_reg_ram_bypass_if.sv
// Writer/reader bus between the envelope pipeline and the state store.
interface st_reg_ram_bypass_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 53
);
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] wr_data;
    logic              re;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              init_busy;

    modport master (
        output we, wr_addr, wr_mask, wr_data, re, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  we, wr_addr, wr_mask, wr_data, re, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/st_reg_ram_bypass_core.sv
// Dual-port read-first RAM with per-bit write mask; out-of-range accesses
// drop the write and read back zero.
module st_reg_ram_core #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 53
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_mask,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_q
);
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    logic              w_wr_ok;
    logic              w_rd_ok;

    assign w_wr_ok = ({1'b0, i_wr_addr} < LP_DEPTH);
    assign w_rd_ok = ({1'b0, i_rd_addr} < LP_DEPTH);

    always_ff @(posedge i_clk) begin
        if (i_we && w_wr_ok) begin
            r_mem[i_wr_addr] <= (r_mem[i_wr_addr] & ~i_wr_mask) | (i_wr_data & i_wr_mask);
        end
    end

    // Output only moves on a read so downstream can rely on it holding.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= w_rd_ok ? r_mem[i_rd_addr] : '0;
        end
    end

    assign o_rd_q = r_q;

endmodule

// File: rtl/st_reg_ram_bypass.sv
// Per-(voice,envelope) state store: clear sweep after reset, masked writes,
// same-cycle read/write bypass and optional output register.
//   state | meaning
//   CLEAR | sweeping INIT_VALUE into every entry, user access ignored
//   RUN   | normal read/write service
module st_reg_ram_bypass
    import st_reg_pkg::*;
#(
    parameter int                    VOICES     = 32,
    parameter int                    V_ENVS     = 8,
    parameter int                    V_WIDTH    = 5,
    parameter int                    E_WIDTH    = 3,
    parameter int                    DATA_W     = 53,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_W-1:0]     INIT_VALUE = '0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    st_reg_ram_bypass_if.slave    bus
);
    localparam int              ADDR_W   = st_addr_w(V_WIDTH, E_WIDTH);
    localparam int              DEPTH    = VOICES * V_ENVS;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

    st_state_e         r_state;
    st_state_e         w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              w_busy;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_mask;
    logic [DATA_W-1:0] w_ram_data;
    logic              w_ram_re;
    logic              w_byp;
    logic [DATA_W-1:0] w_ram_q;
    logic [DATA_W-1:0] w_merged;
    logic              r_v1;
    logic [DATA_W-1:0] r_byp_mask;
    logic [DATA_W-1:0] r_byp_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_cnt <= (r_cnt == LP_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = bus.wr_addr;
        w_ram_mask  = bus.wr_mask;
        w_ram_data  = bus.wr_data;
        w_ram_re    = 1'b0;
        w_byp       = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy     = 1'b1;
                w_ram_we   = 1'b1;
                w_ram_addr = r_cnt;
                w_ram_mask = '1;
                w_ram_data = INIT_VALUE;
                if (r_cnt == LP_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_ram_we = bus.we;
                w_ram_re = bus.re;
                w_byp    = bus.we && bus.re && (bus.wr_addr == bus.rd_addr)
                           && ({1'b0, bus.rd_addr} < LP_DEPTH);
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    st_reg_ram_core #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_core (
        .i_clk     (i_clk),
        .i_rst     (i_reset),
        .i_we      (w_ram_we),
        .i_wr_addr (w_ram_addr),
        .i_wr_mask (w_ram_mask),
        .i_wr_data (w_ram_data),
        .i_re      (w_ram_re),
        .i_rd_addr (bus.rd_addr),
        .o_rd_q    (w_ram_q)
    );

    // RAM returns pre-write contents on a collision; a zero mask here means
    // the read stage passes RAM data through untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_v1       <= 1'b0;
            r_byp_mask <= '0;
            r_byp_data <= '0;
        end else begin
            r_v1 <= w_ram_re;
            if (w_ram_re) begin
                r_byp_mask <= w_byp ? bus.wr_mask : '0;
                r_byp_data <= bus.wr_data;
            end
        end
    end

    assign w_merged = (w_ram_q & ~r_byp_mask) | (r_byp_data & r_byp_mask);

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_v2;
            logic [DATA_W-1:0] r_rd_data;

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_v2      <= 1'b0;
                    r_rd_data <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_rd_data <= w_merged;
                    end
                end
            end

            assign bus.rd_data  = r_rd_data;
            assign bus.rd_valid = r_v2;
        end else begin : g_no_out_reg
            assign bus.rd_data  = w_merged;
            assign bus.rd_valid = r_v1;
        end
    endgenerate

    assign bus.init_busy = w_busy;

endmodule

// File: tb/tb_st_reg_ram_bypass.sv
// Directed bench for st_reg_ram_bypass across three configurations.
module tb_st_reg_ram_bypass;

    localparam logic [52:0] INIT1 = 53'h15_A5A5_A5A5_A5A5;
    localparam logic [52:0] INIT2 = 53'h00_0000_1234_5678;
    localparam logic [52:0] ONES  = 53'h1F_FFFF_FFFF_FFFF;

    logic clk;
    logic rst0, rst1, rst2;
    int   n_checks;
    int   n_fail;

    st_reg_ram_bypass_if #(.ADDR_W(8), .DATA_W(53)) bus0 ();
    st_reg_ram_bypass_if #(.ADDR_W(8), .DATA_W(53)) bus1 ();
    st_reg_ram_bypass_if #(.ADDR_W(8), .DATA_W(53)) bus2 ();

    st_reg_ram_bypass #(.OUT_REG(0)) u_dut0 (
        .i_clk   (clk),
        .i_reset (rst0),
        .bus     (bus0)
    );

    st_reg_ram_bypass #(.OUT_REG(1), .INIT_VALUE(INIT1)) u_dut1 (
        .i_clk   (clk),
        .i_reset (rst1),
        .bus     (bus1)
    );

    st_reg_ram_bypass #(.VOICES(24), .V_ENVS(6), .OUT_REG(0), .INIT_VALUE(INIT2)) u_dut2 (
        .i_clk   (clk),
        .i_reset (rst2),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        bus0.we = 0; bus0.re = 0; bus0.wr_addr = '0; bus0.rd_addr = '0; bus0.wr_mask = '0; bus0.wr_data = '0;
        bus1.we = 0; bus1.re = 0; bus1.wr_addr = '0; bus1.rd_addr = '0; bus1.wr_mask = '0; bus1.wr_data = '0;
        bus2.we = 0; bus2.re = 0; bus2.wr_addr = '0; bus2.rd_addr = '0; bus2.wr_mask = '0; bus2.wr_data = '0;
    endtask

    task automatic test_reset();
        int  n0, n1, n2;
        bit  saw_valid;
        n0 = 0; n1 = 0; n2 = 0; saw_valid = 0;
        rst0 = 1; rst1 = 1; rst2 = 1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus0.init_busy !== 1'b1 || bus0.rd_valid !== 1'b0 || bus0.rd_data !== '0) begin
            $display("FAIL reset_dut0: busy=%b valid=%b data=%h, required 1 0 0", bus0.init_busy, bus0.rd_valid, bus0.rd_data);
            n_fail++;
        end
        n_checks++;
        if (bus1.init_busy !== 1'b1 || bus1.rd_valid !== 1'b0 || bus1.rd_data !== '0) begin
            $display("FAIL reset_dut1: busy=%b valid=%b data=%h, required 1 0 0", bus1.init_busy, bus1.rd_valid, bus1.rd_data);
            n_fail++;
        end
        rst0 = 0; rst1 = 0; rst2 = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus0.init_busy === 1'b1) n0++;
            if (bus1.init_busy === 1'b1) n1++;
            if (bus2.init_busy === 1'b1) n2++;
            if (bus0.rd_valid !== 1'b0 || bus1.rd_valid !== 1'b0 || bus2.rd_valid !== 1'b0) saw_valid = 1;
            if (bus0.init_busy !== 1'b1 && bus1.init_busy !== 1'b1 && bus2.init_busy !== 1'b1) break;
            @(negedge clk);
        end
        n_checks++;
        if (n0 != 256) begin $display("FAIL sweep_len_dut0: got %0d cycles, required 256", n0); n_fail++; end
        n_checks++;
        if (n1 != 256) begin $display("FAIL sweep_len_dut1: got %0d cycles, required 256", n1); n_fail++; end
        n_checks++;
        if (n2 != 144) begin $display("FAIL sweep_len_dut2: got %0d cycles, required 144", n2); n_fail++; end
        n_checks++;
        if (saw_valid) begin $display("FAIL sweep_rd_valid: got rd_valid=1 during sweep, required 0"); n_fail++; end
    endtask

    task automatic test_init_read();
        logic [7:0] addrs [3];
        addrs[0] = 8'd0; addrs[1] = 8'd137; addrs[2] = 8'd255;
        for (int k = 0; k < 3; k++) begin
            bus0.re = 1; bus0.rd_addr = addrs[k];
            bus1.re = 1; bus1.rd_addr = addrs[k];
            @(negedge clk);
            bus0.re = 0; bus1.re = 0;
            n_checks++;
            if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== '0) begin
                $display("FAIL init_read0 addr %0d: valid=%b data=%h, required 1 0", addrs[k], bus0.rd_valid, bus0.rd_data);
                n_fail++;
            end
            n_checks++;
            if (bus1.rd_valid !== 1'b0) begin
                $display("FAIL init_lat1 addr %0d: valid=%b at latency 1, required 0", addrs[k], bus1.rd_valid);
                n_fail++;
            end
            @(negedge clk);
            n_checks++;
            if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== INIT1) begin
                $display("FAIL init_read1 addr %0d: valid=%b data=%h, required 1 %h", addrs[k], bus1.rd_valid, bus1.rd_data, INIT1);
                n_fail++;
            end
            n_checks++;
            if (bus0.rd_valid !== 1'b0) begin
                $display("FAIL init_valid_drop0 addr %0d: valid=%b, required 0", addrs[k], bus0.rd_valid);
                n_fail++;
            end
        end
    endtask

    task automatic test_masked_write();
        bus0.we = 1; bus0.wr_addr = 8'h2A; bus0.wr_data = ONES; bus0.wr_mask = ONES;
        @(negedge clk);
        bus0.wr_data = '0; bus0.wr_mask = 53'hFFFF;
        @(negedge clk);
        bus0.we = 0; bus0.re = 1; bus0.rd_addr = 8'h2A;
        @(negedge clk);
        bus0.re = 0;
        n_checks++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 53'h1F_FFFF_FFFF_0000) begin
            $display("FAIL masked_write: valid=%b data=%h, required 1 1fffffffff0000", bus0.rd_valid, bus0.rd_data);
            n_fail++;
        end
    endtask

    task automatic test_bypass();
        bus0.we = 1; bus0.wr_addr = 8'd5; bus0.wr_data = 53'h1234; bus0.wr_mask = ONES;
        @(negedge clk);
        bus0.wr_data = 53'hABCD; bus0.wr_mask = 53'hFF00; bus0.re = 1; bus0.rd_addr = 8'd5;
        @(negedge clk);
        bus0.we = 0; bus0.re = 1; bus0.rd_addr = 8'd5;
        n_checks++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== 53'hAB34) begin
            $display("FAIL bypass_merge: valid=%b data=%h, required 1 ab34", bus0.rd_valid, bus0.rd_data);
            n_fail++;
        end
        @(negedge clk);
        bus0.re = 0;
        n_checks++;
        if (bus0.rd_data !== 53'hAB34) begin
            $display("FAIL bypass_followup: data=%h, required ab34", bus0.rd_data);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (bus0.rd_valid !== 1'b0 || bus0.rd_data !== 53'hAB34) begin
            $display("FAIL hold_data: valid=%b data=%h, required 0 ab34", bus0.rd_valid, bus0.rd_data);
            n_fail++;
        end
        bus0.we = 1; bus0.wr_addr = 8'd5; bus0.wr_data = 53'hFFFF; bus0.wr_mask = '0;
        bus0.re = 1; bus0.rd_addr = 8'd5;
        @(negedge clk);
        bus0.we = 1; bus0.wr_addr = 8'd6; bus0.wr_data = 53'h77; bus0.wr_mask = ONES;
        bus0.re = 1; bus0.rd_addr = 8'd5;
        n_checks++;
        if (bus0.rd_data !== 53'hAB34) begin
            $display("FAIL bypass_zero_mask: data=%h, required ab34", bus0.rd_data);
            n_fail++;
        end
        @(negedge clk);
        bus0.we = 0; bus0.re = 1; bus0.rd_addr = 8'd6;
        n_checks++;
        if (bus0.rd_data !== 53'hAB34) begin
            $display("FAIL diff_addr_read: data=%h, required ab34", bus0.rd_data);
            n_fail++;
        end
        @(negedge clk);
        bus0.re = 0;
        n_checks++;
        if (bus0.rd_data !== 53'h77) begin
            $display("FAIL diff_addr_write: data=%h, required 77", bus0.rd_data);
            n_fail++;
        end
        bus1.we = 1; bus1.wr_addr = 8'd9; bus1.wr_data = '0; bus1.wr_mask = 53'hFF;
        bus1.re = 1; bus1.rd_addr = 8'd9;
        @(negedge clk);
        bus1.we = 0; bus1.re = 0;
        @(negedge clk);
        n_checks++;
        if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== 53'h15_A5A5_A5A5_A500) begin
            $display("FAIL bypass_outreg: valid=%b data=%h, required 1 15a5a5a5a5a500", bus1.rd_valid, bus1.rd_data);
            n_fail++;
        end
    endtask

    task automatic test_clear_ignore();
        int n;
        bit saw_valid;
        n = 0; saw_valid = 0;
        rst0 = 1;
        @(negedge clk);
        rst0 = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus0.init_busy !== 1'b1) break;
            n++;
            if (bus0.rd_valid !== 1'b0) saw_valid = 1;
            if (n == 11) begin
                bus0.we = 1; bus0.wr_addr = 8'd3; bus0.wr_data = 53'h55; bus0.wr_mask = ONES;
                bus0.re = 1; bus0.rd_addr = 8'd3;
            end else begin
                bus0.we = 0; bus0.re = 0;
            end
            @(negedge clk);
        end
        bus0.we = 0; bus0.re = 0;
        n_checks++;
        if (n != 256) begin $display("FAIL clear_restart_len: got %0d cycles, required 256", n); n_fail++; end
        n_checks++;
        if (saw_valid) begin $display("FAIL clear_rd_valid: got rd_valid=1 during sweep, required 0"); n_fail++; end
        bus0.re = 1; bus0.rd_addr = 8'd3;
        @(negedge clk);
        bus0.rd_addr = 8'd5;
        n_checks++;
        if (bus0.rd_valid !== 1'b1 || bus0.rd_data !== '0) begin
            $display("FAIL clear_drop_write: valid=%b data=%h, required 1 0", bus0.rd_valid, bus0.rd_data);
            n_fail++;
        end
        @(negedge clk);
        bus0.re = 0;
        n_checks++;
        if (bus0.rd_data !== '0) begin
            $display("FAIL clear_reinit: data=%h, required 0", bus0.rd_data);
            n_fail++;
        end
    endtask

    task automatic test_reset_inflight();
        int  n;
        bit  saw_valid;
        n = 0; saw_valid = 0;
        bus1.re = 1; bus1.rd_addr = 8'd9;
        @(negedge clk);
        bus1.re = 0; rst1 = 1;
        if (bus1.rd_valid !== 1'b0) saw_valid = 1;
        @(negedge clk);
        if (bus1.rd_valid !== 1'b0) saw_valid = 1;
        n_checks++;
        if (saw_valid) begin $display("FAIL inflight_valid: got rd_valid=1 across reset, required 0"); n_fail++; end
        n_checks++;
        if (bus1.rd_data !== '0 || bus1.init_busy !== 1'b1) begin
            $display("FAIL inflight_clear: data=%h busy=%b, required 0 1", bus1.rd_data, bus1.init_busy);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (bus1.init_busy !== 1'b1 || bus1.rd_valid !== 1'b0) begin
            $display("FAIL reset_held: busy=%b valid=%b, required 1 0", bus1.init_busy, bus1.rd_valid);
            n_fail++;
        end
        rst1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (bus1.init_busy !== 1'b1) break;
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 256) begin $display("FAIL inflight_sweep_len: got %0d cycles, required 256", n); n_fail++; end
        bus1.re = 1; bus1.rd_addr = 8'd9;
        @(negedge clk);
        bus1.re = 0;
        @(negedge clk);
        n_checks++;
        if (bus1.rd_valid !== 1'b1 || bus1.rd_data !== INIT1) begin
            $display("FAIL inflight_reinit: valid=%b data=%h, required 1 %h", bus1.rd_valid, bus1.rd_data, INIT1);
            n_fail++;
        end
    endtask

    task automatic test_out_of_range();
        int bad;
        bad = 0;
        bus2.re = 1; bus2.rd_addr = 8'd10;
        @(negedge clk);
        bus2.rd_addr = 8'd150;
        n_checks++;
        if (bus2.rd_valid !== 1'b1 || bus2.rd_data !== INIT2) begin
            $display("FAIL oor_pre_read: valid=%b data=%h, required 1 %h", bus2.rd_valid, bus2.rd_data, INIT2);
            n_fail++;
        end
        @(negedge clk);
        bus2.re = 0;
        n_checks++;
        if (bus2.rd_valid !== 1'b1 || bus2.rd_data !== '0) begin
            $display("FAIL oor_read: valid=%b data=%h, required 1 0", bus2.rd_valid, bus2.rd_data);
            n_fail++;
        end
        bus2.we = 1; bus2.wr_addr = 8'd150; bus2.wr_data = ONES; bus2.wr_mask = ONES;
        bus2.re = 1; bus2.rd_addr = 8'd150;
        @(negedge clk);
        bus2.we = 0;
        n_checks++;
        if (bus2.rd_valid !== 1'b1 || bus2.rd_data !== '0) begin
            $display("FAIL oor_bypass: valid=%b data=%h, required 1 0", bus2.rd_valid, bus2.rd_data);
            n_fail++;
        end
        for (int a = 0; a < 144; a++) begin
            bus2.re = 1; bus2.rd_addr = 8'(a);
            @(negedge clk);
            n_checks++;
            if (bus2.rd_valid !== 1'b1 || bus2.rd_data !== INIT2) begin
                $display("FAIL oor_scan addr %0d: valid=%b data=%h, required 1 %h", a, bus2.rd_valid, bus2.rd_data, INIT2);
                n_fail++;
                bad++;
            end
        end
        bus2.re = 1; bus2.rd_addr = 8'd150;
        @(negedge clk);
        bus2.re = 0;
        n_checks++;
        if (bus2.rd_valid !== 1'b1 || bus2.rd_data !== '0) begin
            $display("FAIL oor_reread: valid=%b data=%h, required 1 0", bus2.rd_valid, bus2.rd_data);
            n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_all();
        test_reset();
        test_init_read();
        test_masked_write();
        test_bypass();
        test_clear_ignore();
        test_reset_inflight();
        test_out_of_range();
        idle_all();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
